// File: rtl/byte_lane_arbiter_if.sv
// Requester-side and packer-side signals of byte_lane_arbiter, bundled as one interface.
// slave = arbiter view, master = environment (requesters + packer) view.
interface byte_lane_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int GW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         data_out;
   logic                      valid_out;
   logic [1:0]                byte_idx;
   logic                      word_last;
   logic [GW-1:0]             grant_id;
   logic                      busy;

   modport slave (
      input  req_valid, req_data,
      output req_ready, data_out, valid_out, byte_idx, word_last, grant_id, busy
   );

   modport master (
      output req_valid, req_data,
      input  req_ready, data_out, valid_out, byte_idx, word_last, grant_id, busy
   );
endinterface

// File: rtl/byte_lane_arbiter.sv
// Grants the shared 8-to-32 packer to one requester per 4-byte word, round-robin by default.
// Define ARB_FIXED_PRIORITY_EN for fixed priority (lane 0 highest, pointer removed).
module byte_lane_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
) (
   input logic                 clk_4f,
   input logic                 reset,
   byte_lane_arbiter_if.slave  bus
);
   localparam int GW = $clog2(NUM_REQ);

   typedef enum logic {IDLE, XFER} state_t;

   state_t              state_q, state_d;
   logic [GW-1:0]       grant_q, grant_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic [1:0]          idx_q, idx_d;
   logic                last_q, last_d;
   logic [GW-1:0]       arb_start_c;
   logic [GW-1:0]       winner_c;
   logic                found_c;
   logic                accept_c;
   logic [DATA_W-1:0]   lane_byte_c;
   int                  lane_c;
`ifndef ARB_FIXED_PRIORITY_EN
   logic [GW-1:0]       ptr_q, ptr_d;
   logic [GW-1:0]       next_ptr_c;

   assign next_ptr_c  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
   // At word completion the search already starts past the current grantee.
   assign arb_start_c = (state_q == XFER) ? next_ptr_c : ptr_q;
`else
   assign arb_start_c = '0;
`endif

   assign accept_c    = (state_q == XFER) && bus.req_valid[grant_q];
   assign lane_byte_c = bus.req_data[int'(grant_q)*DATA_W +: DATA_W];

   always_comb begin
      // NOTE: every variable written here gets a default first, so no path can infer a latch.
      found_c  = 1'b0;
      winner_c = '0;
      lane_c   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         lane_c = (int'(arb_start_c) + k) % NUM_REQ;
         if (!found_c && bus.req_valid[lane_c]) begin
            found_c  = 1'b1;
            winner_c = GW'(lane_c);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      idx_d   = idx_q;
      valid_d = 1'b0;
      last_d  = 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_d   = ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (found_c) begin
               grant_d = winner_c;
               cnt_d   = '0;
               state_d = XFER;
            end
         end
         XFER: begin
            if (accept_c) begin
               data_d  = lane_byte_c;
               valid_d = 1'b1;
               idx_d   = cnt_q;
               last_d  = (cnt_q == 2'd3);
               cnt_d   = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
`ifndef ARB_FIXED_PRIORITY_EN
                  ptr_d = next_ptr_c;
`endif
                  if (found_c) grant_d = winner_c;
                  else         state_d = IDLE;
               end
            end
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         idx_q   <= '0;
         last_q  <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
         ptr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
`ifndef ARB_FIXED_PRIORITY_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   // Ready depends only on registered state, never on req_valid.
   always_comb begin
      bus.req_ready = '0;
      if (state_q == XFER) bus.req_ready[grant_q] = 1'b1;
   end

   assign bus.data_out  = data_q;
   assign bus.valid_out = valid_q;
   assign bus.byte_idx  = idx_q;
   assign bus.word_last = last_q;
   assign bus.grant_id  = grant_q;
   assign bus.busy      = (state_q == XFER);
endmodule

// File: doc/byte_lane_arbiter.md
# byte_lane_arbiter

Round-robin arbiter and word sequencer that shares the 8-to-32 byte packer among NUM_REQ independent byte-stream requesters. It grants the packer one requester at a time for exactly one 4-byte word, so a packed 32-bit word never mixes bytes from different sources. It forwards the granted bytes to the packer with a byte index and end-of-word marker, all in the clk_4f domain.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8
- DATA_W, 8, byte width
- GW, $clog2(NUM_REQ), grant-id width (derived, not overridden)
- clk_4f  in  1  sole clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately, 1 = run
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; lane i at [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit high
- data_out  out  DATA_W  byte to packer (registered)
- valid_out  out  1  data_out valid (registered)
- byte_idx  out  2  position of data_out in current word, 0..3
- word_last  out  1  high with the 4th byte of a word
- grant_id  out  GW  requester currently owning the packer (registered)
- busy  out  1  high while a word is in progress

## Operation
- States: IDLE, XFER.
- IDLE: req_ready all 0. If any req_valid is 1, pick winner, load grant_id, clear byte counter, go XFER. Else stay.
- XFER: req_ready[grant_id]=1, all other bits 0. Byte accepted when req_valid[grant_id] & req_ready[grant_id].
- Per accepted byte: data_out <= lane byte, valid_out <= 1, byte_idx <= counter, word_last <= (counter==3), counter++.
- Cycle with no acceptance (stall): valid_out <= 0, word_last <= 0; data_out and byte_idx hold; grant held indefinitely, other lanes stay blocked.
- Word completion (4th acceptance): pointer <= grant_id+1 mod NUM_REQ; in the same cycle re-arbitrate on current req_valid (grantee included, at lowest rank). Winner → stay XFER with new grant_id, counter 0 (no bubble). No requester → IDLE.
- Round-robin: search starts at pointer, ascending, wraps at NUM_REQ-1 → 0.
- busy = (state==XFER).
- Counter is 2 bits; wraps 3→0 only on word completion.

## Timing
- Reset (reset=0) values: state IDLE, pointer 0, counter 0, grant_id 0, data_out 0, valid_out 0, byte_idx 0, word_last 0, busy 0, req_ready 0.
- req_ready is decoded from registered state/grant_id only; no combinational path req_valid → req_ready.
- Latency: byte accepted in cycle N appears on data_out/valid_out in cycle N+1.
- IDLE → first acceptance: 1 cycle (grant registered in cycle N, ready in N+1).
- Back-to-back words, continuous valids: one byte per clk_4f, no gaps; 4 clk_4f = one clk_f word.
- Reset mid-word: partial word dropped, no word_last issued; after release arbitration restarts with pointer 0.
- req_valid change on a non-granted lane mid-word: no effect until word completion.

## Configuration
- ARB_FIXED_PRIORITY_EN defined: pointer unused; every arbitration picks the lowest-index valid requester (lane 0 highest). Starvation of higher lanes allowed.
- Not defined: round-robin as described above (default build).

## Test plan
- Hold reset=0 for 3 cycles, req_valid=4'hF → all outputs 0, req_ready=0; after release, grant_id=0 first.
- Only lane 2 valid, bytes 0x2F,0x5E,0x8D,0xBC → grant_id=2, data_out sequence 0x2F..0xBC on 4 consecutive cycles, byte_idx 0..3, word_last only with 0xBC, each one cycle after acceptance; then busy=0.
- All four lanes valid continuously → grants 0,1,2,3,0; 16 consecutive valid_out=1 cycles, word_last every 4th.
- Lane 1 granted, drops valid for 2 cycles after byte 1 while lane 3 valid → valid_out=0 for 2 cycles, grant_id stays 1, req_ready[3]=0; resumes with byte_idx 2.
- reset=0 asserted after byte_idx 2 of lane 0 → outputs clear within the same cycle, no word_last; after release with lanes 0,1 valid, grant_id=0.
- With ARB_FIXED_PRIORITY_EN, lanes 0 and 3 valid continuously → every word granted to lane 0, req_ready[3] never 1.
